regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the core's 2-read/1-write register file.
- Adds a synchronous-reset clear sweep, per-register scoreboard (pending) bits, and write-to-read bypass.
- Sits between decode (read ports, lock issue) and writeback (write port) of the CPU datapath; lets the control unit stall on not-yet-written operands.

Parameters:
- W, 8, data path width in bits.
- D, 4, address pointer width; depth is 2**D registers.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sweep has finished.
- write_en  in  1  writeback strobe.
- Waddr  in  D  write address.
- data_in  in  W  write data.
- lock_en  in  1  marks lock_addr pending (producer issued).
- lock_addr  in  D  register to mark pending.
- RaddrA  in  D  read address A.
- RaddrB  in  D  read address B.
- data_out_a  out  W  read data A.
- data_out_b  out  W  read data B.
- valid_a  out  1  register A is not pending.
- valid_b  out  1  register B is not pending.
- pending_cnt  out  D+1  number of registers currently pending.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Storage: 2**D x W array; no per-entry reset flops.
- FSM states:
  - INIT: entered on any cycle with reset=1, including reset mid-operation. Sweep counter clr_ptr=0, pending vector=0, pending_cnt=0.
  - INIT with reset=0: each cycle writes 0 to Registers[clr_ptr] and increments clr_ptr. When clr_ptr==2**D-1, that entry is written and the FSM moves to READY next cycle.
  - Sweep timing: exactly 2**D cycles after reset deasserts; ready rises on cycle 2**D+1.
  - READY: normal operation. Exits only via reset.
- During INIT:
  - write_en and lock_en are ignored.
  - data_out_a/b=0, valid_a/b=0, ready=0.
  - Reset value of every output is 0.
- Reads (READY) are combinational:
  - data_out_x = Registers[Raddr_x].
  - valid_x = ~pending[Raddr_x].
- Bypass: if write_en && Waddr==Raddr_x, then data_out_x=data_in and valid_x=1, in the same cycle.
- Lock gating: lock_en does not affect same-cycle valid; the pending bit is visible from the next cycle.
- Write (posedge, READY): Registers[Waddr] <= data_in; pending[Waddr] <= 0.
- Lock (posedge, READY): pending[lock_addr] <= 1.
- Simultaneous lock and write, same address: lock wins (a new producer supersedes). Data is still written, pending stays 1, count unchanged.
- Write to a non-pending register: legal. Data is written; pending and count are unchanged.
- Lock of an already-pending register: no change to pending or count.
- pending_cnt: +1 on a 0->1 pending transition, -1 on 1->0; both in one cycle gives net 0. Never wraps; maximum 2**D fits in D+1 bits.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero; writes and locks to address 0 are ignored.
  - Reads of address 0 return 0 with valid=1, including the bypass case.
  - Reads in INIT still return valid=0.
  - pending_cnt maximum becomes 2**D-1.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_pkg: default W/D constants and the state enum {INIT, READY}.
- Sub-module rf_scoreboard: pending vector, pending_cnt, lock/write priority, clear on reset.
- Array, sweep FSM and bypass muxes stay in regfile_sb.

Test Plan:
- Reset sweep: assert reset 1 cycle, then hold write_en=1, Waddr=3, data_in=8'hAA throughout. Required:
  - ready=0 for 16 cycles, then 1.
  - Reading addr 3 gives 8'h00 (INIT writes ignored).
  - Every address reads 0, valid=1.
- Bypass: READY; write 8'h5C to r7 while RaddrA=7. Required: data_out_a=8'h5C, valid_a=1 in the same cycle; after the edge, 8'h5C is stored.
- Scoreboard: lock r2, then r9.
  - Required: pending_cnt 0->1->2; valid_b=0 for RaddrB=2.
  - Then write r2=8'h11. Required: valid_b=1, pending_cnt=1.
- Lock/write collision: r4 pending; same cycle lock_en=1 and write_en=1 to r4 with 8'h33. Required: data 8'h33 stored, r4 still pending, pending_cnt unchanged.
- Reset mid-operation: 3 registers pending, assert reset. Required next cycle: pending_cnt=0, ready=0, valid_a/b=0; sweep restarts from clr_ptr=0.
- REGFILE_ZERO_REG_EN: write 8'hFF to r0 and lock r0. Required: r0 reads 0, valid=1, pending_cnt=0 (with the macro defined).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the scoreboarded register file.
// Optional build macro (see regfile_sb): REGFILE_ZERO_REG_EN.
package regfile_pkg;

    localparam int W_DEF = 8;
    localparam int D_DEF = 4;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits plus a running count of pending registers.
// Requests arrive already qualified (READY state, zero-register filtering).
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int D = D_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lock_fire,
    input  logic [D-1:0]        lock_addr,
    input  logic                write_fire,
    input  logic [D-1:0]        write_addr,
    output logic [(2**D)-1:0]   pending,
    output logic [D:0]          pending_cnt
);

    localparam int DEPTH = 2**D;

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [D:0]       cnt_q, cnt_d;
    logic             inc, dec;

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pending_d = pending_q;
        // Write clears first, lock sets second: a same-address lock overrides the clear.
        if (write_fire) pending_d[write_addr] = 1'b0;
        if (lock_fire)  pending_d[lock_addr]  = 1'b1;
    end

    assign inc = lock_fire && !pending_q[lock_addr];
    assign dec = write_fire && pending_q[write_addr]
                 && !(lock_fire && (lock_addr == write_addr));

    always_comb begin
        cnt_d = cnt_q;
        unique case ({inc, dec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending     = pending_q;
    assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with reset clear sweep, scoreboard and write bypass.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int D = D_DEF
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ready,
    input  logic          write_en,
    input  logic [D-1:0]  Waddr,
    input  logic [W-1:0]  data_in,
    input  logic          lock_en,
    input  logic [D-1:0]  lock_addr,
    input  logic [D-1:0]  RaddrA,
    input  logic [D-1:0]  RaddrB,
    output logic [W-1:0]  data_out_a,
    output logic [W-1:0]  data_out_b,
    output logic          valid_a,
    output logic          valid_b,
    output logic [D:0]    pending_cnt
);

    localparam int DEPTH = 2**D;

    state_e           state_q, state_d;
    logic [D-1:0]     clr_ptr_q, clr_ptr_d;
    logic [W-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             is_ready;
    logic             wr_fire, lk_fire;
    logic             wr_zero, lk_zero, ra_zero, rb_zero;

    assign is_ready = (state_q == READY);

`ifdef REGFILE_ZERO_REG_EN
    assign wr_zero = (Waddr     == '0);
    assign lk_zero = (lock_addr == '0);
    assign ra_zero = (RaddrA    == '0);
    assign rb_zero = (RaddrB    == '0);
`else
    assign wr_zero = 1'b0;
    assign lk_zero = 1'b0;
    assign ra_zero = 1'b0;
    assign rb_zero = 1'b0;
`endif

    assign wr_fire = is_ready && write_en && !wr_zero;
    assign lk_fire = is_ready && lock_en  && !lk_zero;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == INIT) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) state_d = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // NOTE: the array has no reset; the INIT sweep zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) regs_q[clr_ptr_q] <= '0;
            else if (wr_fire)    regs_q[Waddr]     <= data_in;
        end
    end

    rf_scoreboard #(.D(D)) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .lock_fire   (lk_fire),
        .lock_addr   (lock_addr),
        .write_fire  (wr_fire),
        .write_addr  (Waddr),
        .pending     (pending),
        .pending_cnt (pending_cnt)
    );

    // Bypass uses the raw write strobe; the zero register overrides it.
    always_comb begin
        data_out_a = '0;
        valid_a    = 1'b0;
        if (is_ready) begin
            if (ra_zero) begin
                data_out_a = '0;
                valid_a    = 1'b1;
            end else if (write_en && (Waddr == RaddrA)) begin
                data_out_a = data_in;
                valid_a    = 1'b1;
            end else begin
                data_out_a = regs_q[RaddrA];
                valid_a    = !pending[RaddrA];
            end
        end
    end

    always_comb begin
        data_out_b = '0;
        valid_b    = 1'b0;
        if (is_ready) begin
            if (rb_zero) begin
                data_out_b = '0;
                valid_b    = 1'b1;
            end else if (write_en && (Waddr == RaddrB)) begin
                data_out_b = data_in;
                valid_b    = 1'b1;
            end else begin
                data_out_b = regs_q[RaddrB];
                valid_b    = !pending[RaddrB];
            end
        end
    end

    assign ready = is_ready;

endmodule
